// File: rtl/cache_req_arbiter.sv
// rtl/cache_req_arbiter.sv - round-robin arbiter sharing one cache lookup port
//
// Serialises lookups from NUM_REQ trace requesters onto a single cache port,
// samples the cache's registered hit_flag two cycles after issue, returns a
// tagged response and keeps per-requester hit/miss counters.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   req_valid/addr  - per-requester lookup request (addr flattened, ADDR_WIDTH each)
//   req_ready       - one-hot combinational grant (IDLE only)
//   cache_addr      - registered address to the cache
//   cache_rd_en     - registered read strobe, high for the ISSUE cycle only
//   cache_hit_flag  - cache's registered hit indication
//   resp_valid/id/hit - one-cycle tagged response
//   hit_cnt/miss_cnt  - per-requester counters (flattened, CNT_W each)
//   cnt_clr         - synchronous clear of all counters
//   busy            - FSM not in IDLE
module cache_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_W      = 32,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [ADDR_WIDTH-1:0]         cache_addr,
  output logic                          cache_rd_en,
  input  logic                          cache_hit_flag,
  output logic                          resp_valid,
  output logic [ID_W-1:0]               resp_id,
  output logic                          resp_hit,
  output logic [NUM_REQ*CNT_W-1:0]      hit_cnt,
  output logic [NUM_REQ*CNT_W-1:0]      miss_cnt,
  input  logic                          cnt_clr,
  output logic                          busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] owner;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] grant_id;
  logic            grant_any;
  logic            grant_fire;

  logic [CNT_W-1:0] hit_cnt_r  [NUM_REQ];
  logic [CNT_W-1:0] miss_cnt_r [NUM_REQ];

  // Circular search starting one past the previous winner, so the most
  // recently served requester has the lowest priority.
  always_comb begin : grant_search
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_id  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!grant_any && req_valid[idx[ID_W-1:0]]) begin
        grant_any = 1'b1;
        grant_id  = idx[ID_W-1:0];
      end
    end
  end

  assign grant_fire = (state == IDLE) && grant_any && !rst;
  assign req_ready  = grant_fire ? (NUM_REQ'(1) << grant_id) : '0;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_addr  <= '0;
      cache_rd_en <= 1'b0;
      owner       <= '0;
      last_grant  <= ID_W'(NUM_REQ - 1);
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_hit    <= 1'b0;
    end else begin
      resp_valid  <= 1'b0;
      cache_rd_en <= 1'b0;
      if (state == IDLE && grant_any) begin
        cache_addr  <= req_addr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
        cache_rd_en <= 1'b1;
        owner       <= grant_id;
        last_grant  <= grant_id;
      end
      // hit_flag is registered by the cache on the ISSUE closing edge, so it
      // describes this lookup during RESP.
      if (state == RESP) begin
        resp_valid <= 1'b1;
        resp_hit   <= cache_hit_flag;
        resp_id    <= owner;
      end
    end
  end

  // Clear takes priority over a coincident RESP increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        hit_cnt_r[i]  <= '0;
        miss_cnt_r[i] <= '0;
      end
    end else if (cnt_clr) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        hit_cnt_r[i]  <= '0;
        miss_cnt_r[i] <= '0;
      end
    end else if (state == RESP) begin
      if (cache_hit_flag) begin
        hit_cnt_r[owner] <= hit_cnt_r[owner] + CNT_W'(1);
      end else begin
        miss_cnt_r[owner] <= miss_cnt_r[owner] + CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt_flat
    assign hit_cnt[i*CNT_W +: CNT_W]  = hit_cnt_r[i];
    assign miss_cnt[i*CNT_W +: CNT_W] = miss_cnt_r[i];
  end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// tb/tb_cache_req_arbiter.sv - self-checking bench for cache_req_arbiter
module tb_cache_req_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int CW = 32;
  localparam int IW = 2;
  localparam int FW = N * CW;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N-1:0]      req_ready;
  logic [AW-1:0]     cache_addr;
  logic              cache_rd_en;
  logic              cache_hit_flag = 1'b0;
  logic              resp_valid;
  logic [IW-1:0]     resp_id;
  logic              resp_hit;
  logic [FW-1:0]     hit_cnt;
  logic [FW-1:0]     miss_cnt;
  logic              cnt_clr;
  logic              busy;

  cache_req_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .cache_addr(cache_addr), .cache_rd_en(cache_rd_en),
    .cache_hit_flag(cache_hit_flag), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_hit(resp_hit), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
    .cnt_clr(cnt_clr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Cache stand-in: unbounded cache, hit iff address was looked up since reset.
  bit seen_c [logic [AW-1:0]];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_hit_flag <= 1'b0;
      seen_c.delete();
    end else if (cache_rd_en) begin
      cache_hit_flag <= seen_c.exists(cache_addr);
      seen_c[cache_addr] = 1'b1;
    end
  end

  int tests, fails, cyc;
  // Reference model: transaction view in cycle numbers.
  int          m_lg, m_free, m_issue, m_resp, m_rid, m_nid;
  bit          m_rhit, m_nhit;
  logic [AW-1:0] m_caddr;
  int unsigned m_hit [N];
  int unsigned m_miss [N];
  bit          m_seen [logic [AW-1:0]];
  bit          pend [N];
  logic [AW-1:0] paddr [N];
  bit          refill, rnd;
  logic        clr_drv;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return AW'($urandom_range(0, 7)) << 8;
  endfunction

  task automatic m_reset();
    m_lg = N - 1; m_free = cyc; m_issue = -1; m_resp = -1;
    m_caddr = '0; m_rid = 0; m_rhit = 0; m_nid = 0; m_nhit = 0;
    for (int i = 0; i < N; i++) begin m_hit[i] = 0; m_miss[i] = 0; end
    m_seen.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, FW'(req_ready), '0);
    chk({tag, "_rd_en"}, FW'(cache_rd_en), '0);
    chk({tag, "_addr"}, FW'(cache_addr), '0);
    chk({tag, "_busy"}, FW'(busy), '0);
    chk({tag, "_rvalid"}, FW'(resp_valid), '0);
    chk({tag, "_rid"}, FW'(resp_id), '0);
    chk({tag, "_rhit"}, FW'(resp_hit), '0);
    chk({tag, "_hitcnt"}, hit_cnt, '0);
    chk({tag, "_misscnt"}, miss_cnt, '0);
  endtask

  // One clock cycle: drive at negedge, check, advance model across the edge.
  task automatic step();
    logic [N-1:0]    v;
    logic [N*AW-1:0] a;
    logic [N-1:0]    exp_rdy;
    logic [FW-1:0]   eh, em;
    int g;
    if (rnd) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1; paddr[i] = rand_addr();
        end
      end
    end
    for (int i = 0; i < N; i++) begin v[i] = pend[i]; a[i*AW +: AW] = paddr[i]; end
    req_valid = v; req_addr = a; cnt_clr = clr_drv;
    #1;
    g = -1;
    if (cyc >= m_free) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_lg + k) % N;
        if (g < 0 && pend[idx]) g = idx;
      end
    end
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    for (int i = 0; i < N; i++) begin eh[i*CW +: CW] = m_hit[i]; em[i*CW +: CW] = m_miss[i]; end
    chk("req_ready", FW'(req_ready), FW'(exp_rdy));
    chk("busy", FW'(busy), FW'(cyc < m_free));
    chk("cache_rd_en", FW'(cache_rd_en), FW'(cyc == m_issue));
    chk("cache_addr", FW'(cache_addr), FW'(m_caddr));
    chk("resp_valid", FW'(resp_valid), FW'(cyc == m_resp));
    chk("resp_id", FW'(resp_id), FW'(m_rid));
    chk("resp_hit", FW'(resp_hit), FW'(m_rhit));
    chk("hit_cnt", hit_cnt, eh);
    chk("miss_cnt", miss_cnt, em);
    if (cyc == m_resp - 1) begin
      m_rid = m_nid; m_rhit = m_nhit;
      if (m_nhit) m_hit[m_nid]++; else m_miss[m_nid]++;
    end
    if (clr_drv) begin
      for (int i = 0; i < N; i++) begin m_hit[i] = 0; m_miss[i] = 0; end
    end
    if (g >= 0) begin
      m_lg = g; m_caddr = paddr[g]; m_issue = cyc + 1; m_resp = cyc + 3; m_free = cyc + 3;
      m_nid = g; m_nhit = m_seen.exists(paddr[g]); m_seen[paddr[g]] = 1'b1;
      if (refill) paddr[g] = rand_addr(); else pend[g] = 1'b0;
    end
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; rnd = 0; refill = 0; clr_drv = 1'b0;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b0; paddr[i] = '0; end
    cnt_clr = 1'b0; req_addr = '0;

    // Reset, with requests present: no grant while rst is high.
    req_valid = '1;
    rst = 1'b1;
    #1;
    chk_reset_vals("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0; req_valid = '0;
    m_reset();

    // Single request: miss.
    pend[0] = 1'b1; paddr[0] = 32'h100;
    repeat (4) step();
    chk("single_miss_cnt0", FW'(miss_cnt[CW-1:0]), FW'(1));

    // Same address again: hit.
    pend[0] = 1'b1; paddr[0] = 32'h100;
    repeat (4) step();
    chk("repeat_hit_cnt0", FW'(hit_cnt[CW-1:0]), FW'(1));
    chk("repeat_miss_cnt0", FW'(miss_cnt[CW-1:0]), FW'(1));

    // Round-robin fairness with all requesters continuously asserting.
    refill = 1;
    for (int i = 0; i < N; i++) begin pend[i] = 1'b1; paddr[i] = rand_addr(); end
    repeat (24) step();
    refill = 0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    repeat (3) step();

    // Skip and wrap: last winner 2, then 0 and 1 requesting.
    pend[2] = 1'b1; paddr[2] = 32'h300;
    repeat (4) step();
    pend[0] = 1'b1; paddr[0] = 32'h400;
    pend[1] = 1'b1; paddr[1] = 32'h500;
    repeat (7) step();

    // Clear colliding with a miss increment.
    pend[3] = 1'b1; paddr[3] = 32'h1234;
    step(); step();
    clr_drv = 1'b1;
    step();
    clr_drv = 1'b0;
    step();
    chk("clr_hit_cnt", hit_cnt, '0);
    chk("clr_miss_cnt", miss_cnt, '0);

    // Reset during ISSUE: lookup dropped.
    pend[1] = 1'b1; paddr[1] = 32'h200;
    step();
    pend[1] = 1'b1;
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk); cyc++;
    chk("midrst_rvalid2", FW'(resp_valid), '0);
    @(negedge clk); cyc++;
    rst = 1'b0;
    m_reset();
    pend[0] = 1'b1; paddr[0] = 32'h600;
    pend[2] = 1'b1; paddr[2] = 32'h700;
    repeat (12) step();

    // Randomised traffic with occasional clears.
    rnd = 1;
    repeat (300) begin
      clr_drv = ($urandom_range(0, 15) == 0);
      step();
    end
    clr_drv = 1'b0;
    rnd = 0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    repeat (4) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
